hdc_msg_framer: RTL and testbench

- Upstream stage of the HDC spam classifier. Receives a message as a byte stream with start-of-frame (sof) and end-of-frame (eof) markers.
- Assembles the bytes into the flat, fixed-width msg bus, with a byte count and a class label, which the encoder/classifier consumes.
- Holds each completed frame stable under a valid/ready handshake until the classifier accepts it. Truncates messages that exceed MAX_LENGTH.

---
 rtl/hdc_pkg.sv | 30 +++
 rtl/hdc_char_fold.sv | 51 +++++
 rtl/hdc_msg_framer.sv | 180 ++++++++++++++++++
 tb/tb_hdc_msg_framer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// ---------------------------------------------------------------------------
// hdc_pkg
//
// Shared definitions for the HDC spam classifier front end.
//
// Contents:
//   HDC_MAX_LENGTH    default maximum number of characters kept per message
//   HDC_BITS_PER_CHAR default character width
//   HDC_LEN_W         default width of the length field
//                     (2**HDC_LEN_W must exceed HDC_MAX_LENGTH)
//   LABEL_*           class label encoding carried alongside each message
//   framer_state_e    state encoding of the message framer
// ---------------------------------------------------------------------------
package hdc_pkg;

    localparam int HDC_MAX_LENGTH    = 200;
    localparam int HDC_BITS_PER_CHAR = 8;
    localparam int HDC_LEN_W         = 8;

    localparam logic [1:0] LABEL_SPAM    = 2'd0;
    localparam logic [1:0] LABEL_HAM     = 2'd1;
    localparam logic [1:0] LABEL_UNKNOWN = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } framer_state_e;

endpackage

// File: rtl/hdc_char_fold.sv
// ---------------------------------------------------------------------------
// hdc_char_fold
//
// Combinational character normaliser applied to every byte before the
// framer stores it.
//
// Configuration macro: HDC_MSG_FRAMER_FOLD_EN
//   undefined : characters pass through unchanged.
//   defined   : 'A'..'Z' become lowercase, 'a'..'z' and '0'..'9' pass
//               through, every other byte becomes a space (0x20). The
//               classifier maps all of those bytes to token 0 anyway, so
//               folding only makes stored messages canonical.
//
// Ports:
//   char_i  in  BITS_PER_CHAR  raw character
//   char_o  out BITS_PER_CHAR  normalised character
// ---------------------------------------------------------------------------
module hdc_char_fold
    import hdc_pkg::*;
#(
    parameter int BITS_PER_CHAR = HDC_BITS_PER_CHAR
) (
    input  logic [BITS_PER_CHAR-1:0] char_i,
    output logic [BITS_PER_CHAR-1:0] char_o
);

`ifdef HDC_MSG_FRAMER_FOLD_EN
    localparam logic [BITS_PER_CHAR-1:0] C_UPPER_A = BITS_PER_CHAR'(8'h41);
    localparam logic [BITS_PER_CHAR-1:0] C_UPPER_Z = BITS_PER_CHAR'(8'h5A);
    localparam logic [BITS_PER_CHAR-1:0] C_LOWER_A = BITS_PER_CHAR'(8'h61);
    localparam logic [BITS_PER_CHAR-1:0] C_LOWER_Z = BITS_PER_CHAR'(8'h7A);
    localparam logic [BITS_PER_CHAR-1:0] C_DIGIT_0 = BITS_PER_CHAR'(8'h30);
    localparam logic [BITS_PER_CHAR-1:0] C_DIGIT_9 = BITS_PER_CHAR'(8'h39);
    localparam logic [BITS_PER_CHAR-1:0] C_SPACE   = BITS_PER_CHAR'(8'h20);
    localparam logic [BITS_PER_CHAR-1:0] C_CASE    = BITS_PER_CHAR'(8'h20);

    always_comb begin
        char_o = C_SPACE;
        if (char_i >= C_UPPER_A && char_i <= C_UPPER_Z) begin
            // Upper and lower case differ only in bit 5 of ASCII.
            char_o = char_i | C_CASE;
        end else if ((char_i >= C_LOWER_A && char_i <= C_LOWER_Z) ||
                     (char_i >= C_DIGIT_0 && char_i <= C_DIGIT_9)) begin
            char_o = char_i;
        end
    end
`else
    assign char_o = char_i;
`endif

endmodule

// File: rtl/hdc_msg_framer.sv
// ---------------------------------------------------------------------------
// hdc_msg_framer
//
// Upstream stage of the HDC spam classifier. Collects a byte stream
// delimited by sof/eof into a flat, zero-padded message bus together with
// its byte count and class label, then holds the completed frame under a
// valid/ready handshake until the classifier takes it. Characters beyond
// MAX_LENGTH are dropped and flagged as truncated.
//
// Configuration macro: HDC_MSG_FRAMER_FOLD_EN (see hdc_char_fold); when
// defined, every byte is case-folded / normalised before it is stored.
//
// Ports:
//   clk           in   1                       clock, rising edge
//   reset         in   1                       synchronous, active-low
//   in_valid      in   1                       input byte valid
//   in_ready      out  1                       framer accepts a byte
//   in_data       in   BITS_PER_CHAR           character byte
//   in_sof        in   1                       first byte of a message
//   in_eof        in   1                       last byte of a message
//   in_label      in   2                       label, sampled on sof byte
//   out_valid     out  1                       completed frame available
//   out_ready     in   1                       downstream takes the frame
//   msg           out  MAX_LENGTH*BITS_PER_CHAR char k at msg[k*W +: W]
//   length        out  LEN_W                   stored byte count
//   label         out  2                       latched label
//   truncated     out  1                       frame exceeded MAX_LENGTH
//   protocol_err  out  1                       one-cycle framing-error pulse
//
// Timing: out_valid rises the cycle after the eof byte is accepted;
// protocol_err pulses the cycle after the offending byte is accepted.
// ---------------------------------------------------------------------------
module hdc_msg_framer
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH    = HDC_MAX_LENGTH,
    parameter int BITS_PER_CHAR = HDC_BITS_PER_CHAR,
    parameter int LEN_W         = HDC_LEN_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BITS_PER_CHAR-1:0]            in_data,
    input  logic                                in_sof,
    input  logic                                in_eof,
    input  logic [1:0]                          in_label,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [MAX_LENGTH*BITS_PER_CHAR-1:0] msg,
    output logic [LEN_W-1:0]                    length,
    output logic [1:0]                          label,
    output logic                                truncated,
    output logic                                protocol_err
);

    localparam int                MSG_W     = MAX_LENGTH * BITS_PER_CHAR;
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LENGTH);
    localparam logic [LEN_W-1:0]  ONE_L     = LEN_W'(1);

    framer_state_e            state_q, state_d;
    logic [MSG_W-1:0]         msg_q, msg_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [1:0]               label_q, label_d;
    logic                     trunc_q, trunc_d;
    logic                     perr_q, perr_d;

    logic [BITS_PER_CHAR-1:0] char_fold;
    logic                     accept;
    logic                     start_frame;
    logic                     append_char;

    hdc_char_fold #(
        .BITS_PER_CHAR (BITS_PER_CHAR)
    ) u_fold (
        .char_i (in_data),
        .char_o (char_fold)
    );

    // The framer is ready in every state except while holding a frame, so
    // acceptance never depends on the incoming byte itself.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            label_q <= 2'b00;
            trunc_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            label_q <= label_d;
            trunc_q <= trunc_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        len_d       = len_q;
        label_d     = label_q;
        trunc_d     = trunc_q;
        perr_d      = 1'b0;
        start_frame = 1'b0;
        append_char = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        start_frame = 1'b1;
                    end else begin
                        // Stray byte outside a frame: dropped, flagged.
                        perr_d = 1'b1;
                    end
                end
            end

            COLLECT: begin
                if (accept) begin
                    if (in_sof) begin
                        // A new sof aborts the frame in progress; the new
                        // frame starts cleanly as if from IDLE.
                        perr_d      = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        if (len_q < MAX_LEN_L) begin
                            append_char = 1'b1;
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (in_eof) begin
                            state_d = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing the whole buffer on sof is what keeps every byte past
        // length at zero for the classifier.
        if (start_frame) begin
            msg_d                    = '0;
            msg_d[BITS_PER_CHAR-1:0] = char_fold;
            len_d                    = ONE_L;
            label_d                  = in_label;
            trunc_d                  = 1'b0;
            state_d                  = in_eof ? HOLD : COLLECT;
        end

        if (append_char) begin
            msg_d[int'(len_q)*BITS_PER_CHAR +: BITS_PER_CHAR] = char_fold;
            len_d                                             = len_q + ONE_L;
        end
    end

    assign msg          = msg_q;
    assign length       = len_q;
    assign label        = label_q;
    assign truncated    = trunc_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_hdc_msg_framer.sv
// ---------------------------------------------------------------------------
// tb_hdc_msg_framer
//
// Bench for hdc_msg_framer. A frame-level reference model (queue of the
// characters of the current / last frame plus a "holding" flag) predicts
// every output each cycle; directed sequences add literal expectations,
// and a randomized phase exercises lengths around MAX_LENGTH, gaps,
// back-pressure and framing violations.
// ---------------------------------------------------------------------------
module tb_hdc_msg_framer;
    import hdc_pkg::*;

    localparam int ML = 200;
    localparam int BW = 8;
    localparam int LW = 8;
    localparam int MW = ML * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_eof = 1'b0;
    logic [1:0]    in_label = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] msg;
    logic [LW-1:0] length;
    logic [1:0]    label;
    logic          truncated;
    logic          protocol_err;

    hdc_msg_framer #(
        .MAX_LENGTH    (ML),
        .BITS_PER_CHAR (BW),
        .LEN_W         (LW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .in_label     (in_label),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .msg          (msg),
        .length       (length),
        .label        (label),
        .truncated    (truncated),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rand_rdy = 1'b0;

    // ---------------- reference model ----------------
    byte unsigned frame_q[$];   // every char of the current/last frame
    bit           m_in_frame = 1'b0;
    bit           m_hold = 1'b0;
    bit           m_perr = 1'b0;
    logic [1:0]   m_label = 2'b00;

    function automatic byte unsigned fold(byte unsigned b);
`ifdef HDC_MSG_FRAMER_FOLD_EN
        if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
        if ((b >= 8'd97 && b <= 8'd122) || (b >= 8'd48 && b <= 8'd57)) return b;
        return 8'h20;
`else
        return b;
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            frame_q.delete();
            m_in_frame = 1'b0;
            m_hold     = 1'b0;
            m_perr     = 1'b0;
            m_label    = 2'b00;
        end else begin
            m_perr = 1'b0;
            if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                if (in_sof) begin
                    m_perr = m_in_frame;
                    frame_q.delete();
                    frame_q.push_back(fold(in_data));
                    m_label    = in_label;
                    m_in_frame = 1'b1;
                end else if (!m_in_frame) begin
                    m_perr = 1'b1;
                end else begin
                    frame_q.push_back(fold(in_data));
                end
                if (m_in_frame && in_eof) begin
                    m_in_frame = 1'b0;
                    m_hold     = 1'b1;
                end
            end
        end
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        int n;
        int nl;
        int bad;
        byte unsigned eb;
        if (chk_en) begin
            n  = frame_q.size();
            nl = (n > ML) ? ML : n;
            chk("out_valid", 64'(out_valid), 64'(m_hold));
            chk("in_ready", 64'(in_ready), 64'(!m_hold));
            chk("protocol_err", 64'(protocol_err), 64'(m_perr));
            chk("length", 64'(length), 64'(nl));
            chk("label", 64'(label), 64'(m_label));
            chk("truncated", 64'(truncated), 64'(n > ML));
            bad = -1;
            eb  = 8'h00;
            for (int k = 0; k < ML; k++) begin
                eb = (k < nl) ? frame_q[k] : 8'h00;
                if (msg[k*BW +: BW] !== eb) begin
                    bad = k;
                    break;
                end
            end
            n_vec++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL msg byte %0d: got %0h, expected %0h (t=%0t)",
                         bad, msg[bad*BW +: BW], eb, $time);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] d, input bit s, input bit e, input logic [1:0] l);
        bit rdy;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        in_label = l;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_data  = 8'($urandom);
        in_label = 2'($urandom);
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout: byte %0h not accepted within 2000 cycles", d);
        end
    endtask

    task automatic send_frame(input int n, input logic [1:0] l, input int max_gap, input bit mid_sof);
        for (int k = 0; k < n; k++) begin
            send(8'($urandom_range(32, 126)), (k == 0) || (mid_sof && k == n / 2),
                 (k == n - 1), l);
            repeat ($urandom_range(0, max_gap)) step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_length"}, 64'(length), 64'd0);
        chk({tag, "_label"}, 64'(label), 64'd0);
        chk({tag, "_truncated"}, 64'(truncated), 64'd0);
        chk({tag, "_msg_zero"}, 64'(|msg), 64'd0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] hi_exp;
        int          nlen;

        reset = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        chk_reset_state("reset");

        // "Hi", label ham, out_ready already high.
        out_ready = 1'b1;
        send(8'h48, 1'b1, 1'b0, LABEL_HAM);
        send(8'h69, 1'b0, 1'b1, LABEL_HAM);
`ifdef HDC_MSG_FRAMER_FOLD_EN
        hi_exp = 16'h6968;
`else
        hi_exp = 16'h6948;
`endif
        chk("hi_out_valid", 64'(out_valid), 64'd1);
        chk("hi_length", 64'(length), 64'd2);
        chk("hi_msg", 64'(msg[15:0]), 64'(hi_exp));
        chk("hi_label", 64'(label), 64'd1);
        chk("hi_truncated", 64'(truncated), 64'd0);
        step();
        chk("hi_released", 64'(out_valid), 64'd0);

        // Single-byte frame "7", then 10 cycles of back-pressure with a
        // second frame pending at the input.
        out_ready = 1'b0;
        send(8'h37, 1'b1, 1'b1, LABEL_SPAM);
        chk("one_length", 64'(length), 64'd1);
        chk("one_msg0", 64'(msg[7:0]), 64'h37);
        chk("one_upper_zero", 64'(|msg[MW-1:8]), 64'd0);
        in_valid = 1'b1; in_data = 8'h41; in_sof = 1'b1; in_eof = 1'b1; in_label = LABEL_UNKNOWN;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_length", 64'(length), 64'd1);
            chk("stall_msg0", 64'(msg[7:0]), 64'h37);
        end
        out_ready = 1'b1;
        step();
        chk("stall_release", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        chk("second_valid", 64'(out_valid), 64'd1);
        chk("second_label", 64'(label), 64'd3);
        chk("second_msg0", 64'(msg[7:0]), 64'(fold(8'h41)));
        step();

        // MAX_LENGTH boundary: 200, 201, 202 bytes.
        for (int f = 0; f < 3; f++) begin
            out_ready = 1'b0;
            nlen = ML + f;
            send_frame(nlen, 2'd2, 0, 1'b0);
            chk("max_length", 64'(length), 64'(ML));
            chk("max_truncated", 64'(truncated), 64'(f != 0));
            out_ready = 1'b1;
            step();
        end

        // Stray byte in IDLE.
        send(8'h55, 1'b0, 1'b0, 2'd0);
        chk("stray_perr", 64'(protocol_err), 64'd1);
        step();
        chk("stray_perr_clear", 64'(protocol_err), 64'd0);

        // sof after five bytes restarts the frame.
        send_frame(5, LABEL_HAM, 0, 1'b0);
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(8'h61 + 8'(k), (k == 0), 1'b0, LABEL_HAM);
        send(8'h7A, 1'b1, 1'b0, 2'd2);
        chk("midsof_perr", 64'(protocol_err), 64'd1);
        chk("midsof_length", 64'(length), 64'd1);
        chk("midsof_label", 64'(label), 64'd2);
        send(8'h62, 1'b0, 1'b0, 2'd0);
        send(8'h63, 1'b0, 1'b1, 2'd0);
        chk("midsof_final_length", 64'(length), 64'd3);
        step();

        // Reset in COLLECT after three bytes.
        send(8'h31, 1'b1, 1'b0, LABEL_HAM);
        send(8'h32, 1'b0, 1'b0, LABEL_HAM);
        send(8'h33, 1'b0, 1'b0, LABEL_HAM);
        do_reset();
        chk_reset_state("rst_collect");
        send_frame(4, LABEL_SPAM, 1, 1'b0);
        chk("post_rst_length", 64'(length), 64'd4);
        step();

        // Reset in HOLD.
        out_ready = 1'b0;
        send_frame(3, LABEL_UNKNOWN, 0, 1'b0);
        step();
        do_reset();
        chk_reset_state("rst_hold");
        out_ready = 1'b1;
        send_frame(6, LABEL_HAM, 0, 1'b0);
        chk("post_rst2_length", 64'(length), 64'd6);
        step();

        // Randomized phase.
        rand_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 2))
                0:       nlen = $urandom_range(1, 8);
                1:       nlen = $urandom_range(ML - 4, ML + 5);
                default: nlen = $urandom_range(1, ML + 30);
            endcase
            if ($urandom_range(0, 9) == 0) send(8'($urandom), 1'b0, 1'($urandom), 2'($urandom));
            send_frame(nlen, 2'($urandom), $urandom_range(0, 2), ($urandom_range(0, 9) == 0) && nlen > 2);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
